// File: rtl/swap_pair_checker.sv
// swap_pair_checker: monitors a two-bit swap source, counts correct exchanges
// and violations over a fixed window, then holds a verdict until re-armed.
module swap_pair_checker #(
  parameter int unsigned WINDOW = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             a_i,
  input  logic             b_i,
  output logic [CNT_W-1:0] swap_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [1:0]       mode_o,
  output logic             done_o,
  output logic             collapse_o
);

  localparam int unsigned      SMP_W   = (WINDOW > 1) ? $clog2(WINDOW + 1) : 1;
  localparam longint unsigned  CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  localparam logic [1:0] MODE_UNDET = 2'b00;
  localparam logic [1:0] MODE_SWAP  = 2'b01;
  localparam logic [1:0] MODE_RACE  = 2'b10;
  localparam logic [1:0] MODE_MIXED = 2'b11;

  // Reject configurations whose window cannot be represented by the counts.
  if (WINDOW < 1) begin : g_bad_window
    $error("swap_pair_checker: WINDOW must be at least 1");
  end
  if (CNT_MAX < 64'(WINDOW)) begin : g_bad_cnt_w
    $error("swap_pair_checker: CNT_W too narrow for WINDOW");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRACK,
    ST_DONE
  } state_t;

  state_t             r_state,    w_state_nxt;
  logic [CNT_W-1:0]   r_swap_cnt, w_swap_nxt;
  logic [CNT_W-1:0]   r_err_cnt,  w_err_nxt;
  logic [1:0]         r_mode,     w_mode_nxt;
  logic               r_done,     w_done_nxt;
  logic               r_collapse, w_collapse_nxt;
  logic               r_prev_a,   w_prev_a_nxt;
  logic               r_prev_b,   w_prev_b_nxt;
  logic [SMP_W-1:0]   r_smp_cnt,  w_smp_nxt;

  // Per-sample classification of the current input against the seeded pair.
  logic             w_informative;
  logic             w_match;
  logic             w_equal;
  logic             w_last;
  logic [CNT_W-1:0] w_swap_upd;
  logic [CNT_W-1:0] w_err_upd;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Sample evaluation: post-update counts for this edge, saturating at all-ones.
  always_comb begin
    w_informative = r_prev_a ^ r_prev_b;
    w_match       = (a_i == r_prev_b) && (b_i == r_prev_a);
    w_equal       = (a_i == b_i);
    w_last        = (r_smp_cnt == SMP_W'(WINDOW - 1));
    w_swap_upd    = r_swap_cnt;
    w_err_upd     = r_err_cnt;
    if (w_informative) begin
      if (w_match) w_swap_upd = sat_inc(r_swap_cnt);
      else         w_err_upd  = sat_inc(r_err_cnt);
    end else if (!w_equal) begin
      w_err_upd = sat_inc(r_err_cnt);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_swap_cnt <= '0;
      r_err_cnt  <= '0;
      r_mode     <= MODE_UNDET;
      r_done     <= 1'b0;
      r_collapse <= 1'b0;
      r_prev_a   <= 1'b0;
      r_prev_b   <= 1'b0;
      r_smp_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_swap_cnt <= w_swap_nxt;
      r_err_cnt  <= w_err_nxt;
      r_mode     <= w_mode_nxt;
      r_done     <= w_done_nxt;
      r_collapse <= w_collapse_nxt;
      r_prev_a   <= w_prev_a_nxt;
      r_prev_b   <= w_prev_b_nxt;
      r_smp_cnt  <= w_smp_nxt;
    end
  end

  // Next-state and next-output logic; everything holds unless a state acts.
  always_comb begin
    w_state_nxt    = r_state;
    w_swap_nxt     = r_swap_cnt;
    w_err_nxt      = r_err_cnt;
    w_mode_nxt     = r_mode;
    w_done_nxt     = r_done;
    w_collapse_nxt = r_collapse;
    w_prev_a_nxt   = r_prev_a;
    w_prev_b_nxt   = r_prev_b;
    w_smp_nxt      = r_smp_cnt;

    unique case (r_state)
      ST_IDLE: begin
        if (en_i) begin
          w_prev_a_nxt   = a_i;
          w_prev_b_nxt   = b_i;
          w_swap_nxt     = '0;
          w_err_nxt      = '0;
          w_collapse_nxt = 1'b0;
          w_mode_nxt     = MODE_UNDET;
          w_smp_nxt      = '0;
          w_state_nxt    = ST_TRACK;
        end
      end

      ST_TRACK: begin
        if (!en_i) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_swap_nxt   = w_swap_upd;
          w_err_nxt    = w_err_upd;
          if (w_informative && w_equal) w_collapse_nxt = 1'b1;
          w_prev_a_nxt = a_i;
          w_prev_b_nxt = b_i;
          w_smp_nxt    = r_smp_cnt + SMP_W'(1);
          if (w_last) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
            if (w_swap_upd != '0 && w_err_upd == '0)      w_mode_nxt = MODE_SWAP;
            else if (w_swap_upd == '0 && w_err_upd != '0) w_mode_nxt = MODE_RACE;
            else if (w_swap_upd != '0)                    w_mode_nxt = MODE_MIXED;
            else                                          w_mode_nxt = MODE_UNDET;
          end
        end
      end

      ST_DONE: begin
        if (!en_i) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b0;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign swap_cnt_o = r_swap_cnt;
  assign err_cnt_o  = r_err_cnt;
  assign mode_o     = r_mode;
  assign done_o     = r_done;
  assign collapse_o = r_collapse;

endmodule

// File: tb/tb_swap_pair_checker.sv
// Directed bench for swap_pair_checker: default build plus a narrow-count build.
module tb_swap_pair_checker;

  logic clk = 1'b0;
  logic rst_n;
  logic en, a, b;
  logic en_s, a_s, b_s;

  logic [7:0] swap_cnt, err_cnt;
  logic [1:0] mode;
  logic       done, collapse;

  logic [2:0] swap_cnt_s, err_cnt_s;
  logic [1:0] mode_s;
  logic       done_s, collapse_s;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  swap_pair_checker #(.WINDOW(8), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en),
    .a_i        (a),
    .b_i        (b),
    .swap_cnt_o (swap_cnt),
    .err_cnt_o  (err_cnt),
    .mode_o     (mode),
    .done_o     (done),
    .collapse_o (collapse)
  );

  swap_pair_checker #(.WINDOW(7), .CNT_W(3)) dut_s (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en_s),
    .a_i        (a_s),
    .b_i        (b_s),
    .swap_cnt_o (swap_cnt_s),
    .err_cnt_o  (err_cnt_s),
    .mode_o     (mode_s),
    .done_o     (done_s),
    .collapse_o (collapse_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply inputs to the main instance, then sample 1 time unit after the edge.
  task automatic drv(input logic e, input logic [1:0] ab);
    en = e;
    {a, b} = ab;
    @(posedge clk);
    #1;
  endtask

  task automatic drv_s(input logic e, input logic [1:0] ab);
    en_s = e;
    {a_s, b_s} = ab;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int sw, input int er,
                           input int md, input int dn, input int co);
    check({tag, ".swap"},     32'(swap_cnt), 32'(sw));
    check({tag, ".err"},      32'(err_cnt),  32'(er));
    check({tag, ".mode"},     32'(mode),     32'(md));
    check({tag, ".done"},     32'(done),     32'(dn));
    check({tag, ".collapse"}, 32'(collapse), 32'(co));
  endtask

  logic [1:0] mx_ab [8] = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b01, 2'b10, 2'b01, 2'b10};
  int         mx_sw [8] = '{1, 2, 2, 2, 2, 3, 4, 5};
  int         mx_er [8] = '{0, 0, 1, 1, 2, 2, 2, 2};
  int         mx_co [8] = '{0, 0, 1, 1, 1, 1, 1, 1};

  initial begin
    rst_n = 1'b0;
    en = 1'b0;   a = 1'b0;   b = 1'b0;
    en_s = 1'b0; a_s = 1'b0; b_s = 1'b0;
    #12;
    check_all("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Correct swap: exact per-edge counts, verdict only after the 8th sample.
    drv(1'b1, 2'b10);
    check_all("swap.seed", 0, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      drv(1'b1, (k % 2 == 1) ? 2'b01 : 2'b10);
      check_all($sformatf("swap.e%0d", k), k, 0, (k == 8) ? 1 : 0, (k == 8) ? 1 : 0, 0);
    end
    drv(1'b1, 2'b11);
    check_all("swap.hold", 8, 0, 1, 1, 0);
    drv(1'b0, 2'b00);
    check_all("swap.release", 8, 0, 1, 0, 0);

    // Race source: one collapse then non-informative equal pairs.
    drv(1'b1, 2'b10);
    check_all("race.seed", 0, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      drv(1'b1, 2'b00);
      check_all($sformatf("race.e%0d", k), 0, 1, (k == 8) ? 2 : 0, (k == 8) ? 1 : 0, 1);
    end
    drv(1'b0, 2'b00);

    // Mixed trace.
    drv(1'b1, 2'b10);
    for (int k = 0; k < 8; k++) begin
      drv(1'b1, mx_ab[k]);
      check_all($sformatf("mixed.e%0d", k + 1), mx_sw[k], mx_er[k],
                (k == 7) ? 3 : 0, (k == 7) ? 1 : 0, mx_co[k]);
    end
    drv(1'b0, 2'b00);

    // Undetermined: only non-informative equal pairs.
    drv(1'b1, 2'b00);
    for (int k = 1; k <= 8; k++) drv(1'b1, (k % 2 == 1) ? 2'b00 : 2'b11);
    check_all("undet", 0, 0, 0, 1, 0);
    drv(1'b0, 2'b00);
    check_all("undet.release", 0, 0, 0, 0, 0);

    // Abort at E3: counts freeze, no verdict.
    drv(1'b1, 2'b10);
    drv(1'b1, 2'b01);
    drv(1'b1, 2'b10);
    check_all("abort.e2", 2, 0, 0, 0, 0);
    drv(1'b0, 2'b11);
    check_all("abort.e3", 2, 0, 0, 0, 0);
    drv(1'b0, 2'b01);
    check_all("abort.idle", 2, 0, 0, 0, 0);

    // Reseed, build up counts, then asynchronous reset after E5.
    drv(1'b1, 2'b10);
    check_all("rst.seed", 0, 0, 0, 0, 0);
    drv(1'b1, 2'b00);
    drv(1'b1, 2'b00);
    drv(1'b1, 2'b01);
    drv(1'b1, 2'b10);
    check_all("rst.e4", 1, 2, 0, 0, 1);
    en = 1'b1; {a, b} = 2'b10;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("rst.async", 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("rst.reseed", 0, 0, 0, 0, 0);
    drv(1'b1, 2'b01);
    drv(1'b1, 2'b10);
    drv(1'b1, 2'b01);
    check_all("rst.fresh", 3, 0, 0, 0, 0);
    drv(1'b0, 2'b00);

    // Narrow counts: seven swaps reach all-ones.
    drv_s(1'b1, 2'b10);
    for (int k = 1; k <= 7; k++) drv_s(1'b1, (k % 2 == 1) ? 2'b01 : 2'b10);
    check("sat.swap",     32'(swap_cnt_s), 32'(7));
    check("sat.swap_err", 32'(err_cnt_s),  32'(0));
    check("sat.swap_mode", 32'(mode_s),    32'(1));
    check("sat.swap_done", 32'(done_s),    32'(1));
    drv_s(1'b1, 2'b11);
    check("sat.hold",     32'(swap_cnt_s), 32'(7));
    // Minimum re-arm gap, then seven violations without collapse.
    drv_s(1'b0, 2'b00);
    check("sat.release",  32'(done_s),     32'(0));
    drv_s(1'b1, 2'b10);
    check("sat.reseed",   32'(swap_cnt_s), 32'(0));
    for (int k = 1; k <= 7; k++) drv_s(1'b1, 2'b10);
    check("sat.err",      32'(err_cnt_s),  32'(7));
    check("sat.err_swap", 32'(swap_cnt_s), 32'(0));
    check("sat.err_mode", 32'(mode_s),     32'(2));
    check("sat.err_coll", 32'(collapse_s), 32'(0));
    check("sat.err_done", 32'(done_s),     32'(1));
    drv_s(1'b0, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
